alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operands; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous discard of all buffered entries.
REQ-005 in_valid  input  1  upstream offers instr/rs1_data/rs2_data this cycle.
REQ-006 in_ready  output  1  block accepts an entry this cycle.
REQ-007 instr  input  32  RISC-V instruction word.
REQ-008 rs1_data  input  32  register-file value of rs1.
REQ-009 rs2_data  input  32  register-file value of rs2.
REQ-010 out_valid  output  1  head entry presented to the ALU.
REQ-011 out_ready  input  1  downstream consumes head entry this cycle.
REQ-012 opA  output  32  ALU operand A.
REQ-013 opB  output  32  ALU operand B.
REQ-014 aluOutSel  output  4  ALU operation select.
REQ-015 rd  output  5  destination register, instr[11:7].
REQ-016 illegal  output  1  head entry is an unsupported instruction.

Function
REQ-017 aluOutSel encoding SHALL be: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1111 pass opA.
REQ-018 Opcode 0110011 (R-type): opA=rs1_data, opB=rs2_data; funct3 000/001/010/011/100/101/110/111 -> add/sll/slt/sltu/xor/srl/or/and with funct7=0000000; funct7=0100000 legal only for funct3 000 (sub) and 101 (sra).
REQ-019 Opcode 0010011 (I-type): opA=rs1_data, opB=sign-extended instr[31:20]; same funct3 map; no sub.
REQ-020 I-type shifts (funct3 001/101): opB={27'b0,instr[24:20]}; instr[31:25] SHALL be 0000000 (slli/srli) or 0100000 (srai only), else illegal.
REQ-021 Opcode 0110111 (LUI): opA={instr[31:12],12'b0}, opB=0, aluOutSel=1111.
REQ-022 Any other opcode or disallowed funct7: illegal=1, opA=0, opB=0, aluOutSel=1111, rd from instr; entry still flows through the handshake.
REQ-023 Decode is combinational on input; decoded fields are stored in a 2-entry in-order FIFO.
REQ-024 Transfer in occurs when in_valid&in_ready; transfer out when out_valid&out_ready.
REQ-025 in_ready SHALL be 1 iff occupancy < 2 (registered state, no combinational dependence on out_ready).
REQ-026 out_valid SHALL be 1 iff occupancy != 0; outputs reflect the oldest entry.
REQ-027 Minimum latency: entry accepted in cycle N is visible with out_valid=1 in cycle N+1.
REQ-028 Occupancy 1 with simultaneous push and pop: occupancy stays 1, new entry becomes head next cycle.
REQ-029 Occupancy 2: in_ready=0; a pop drops occupancy to 1, in_ready=1 next cycle.
REQ-030 Occupancy 0 with out_ready=1: no pop, no underflow; no bypass of input to output.
REQ-031 out_valid held with out_ready=0: opA/opB/aluOutSel/rd/illegal SHALL remain stable.
REQ-032 Read/write pointers wrap modulo 2; order is strictly preserved.
REQ-033 flush=1: occupancy becomes 0 next cycle; a push in the same cycle is discarded; in_ready=1 next cycle.

Reset
REQ-034 rst=1 SHALL set occupancy 0, pointers 0, out_valid=0, in_ready=1, opA=0, opB=0, aluOutSel=0000, rd=0, illegal=0; rst overrides flush and handshakes.
REQ-035 rst asserted mid-operation discards all buffered entries; no entry is emitted after rst.

Verification
REQ-036 R-type sub instr=0x40208033, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, aluOutSel=0001, opA=10, opB=3, rd=0.
REQ-037 addi instr=0xFFF00093 (imm -1) -> opB=0xFFFFFFFF, aluOutSel=0000, rd=1; srai instr=0x40315093 -> opB=3, aluOutSel=1001.
REQ-038 LUI instr=0x123450B7 -> opA=0x12345000, opB=0, aluOutSel=1111; opcode 0x7F or R-type funct7=0100000/funct3=100 -> illegal=1, aluOutSel=1111.
REQ-039 out_ready=0, push 3 back-to-back -> entries 1,2 accepted, in_ready=0 on third; then out_ready=1 -> outputs 1,2,3 in order, outputs stable while stalled.
REQ-040 Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; rst with occupancy 1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue -- RV32I integer-ALU decode plus 2-entry in-order issue buffer.
//
// The instruction offered on the input is decoded combinationally into ALU
// operands and an operation select. The decoded entry is then written into a
// two-deep FIFO. The oldest entry is always shown on the output side.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every buffered entry (a push in the same cycle is dropped)
//   in_valid/ready  upstream handshake for instr, rs1_data, rs2_data
//   out_valid/ready downstream handshake for the head entry
//   opA, opB        ALU operands of the head entry
//   aluOutSel       ALU operation select of the head entry
//   rd              destination register (instr[11:7]) of the head entry
//   illegal         the head entry is an unsupported instruction
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opA,
  output logic [XLEN-1:0] opB,
  output logic [3:0]      aluOutSel,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_XOR  = 4'b0010;
  localparam logic [3:0] SEL_OR   = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_SLT  = 4'b0101;
  localparam logic [3:0] SEL_SLTU = 4'b0110;
  localparam logic [3:0] SEL_SLL  = 4'b0111;
  localparam logic [3:0] SEL_SRL  = 4'b1000;
  localparam logic [3:0] SEL_SRA  = 4'b1001;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      sel;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  // funct3 -> operation select for the "base" (funct7 == 0) variants.
  function automatic logic [3:0] f3_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_sel = SEL_ADD;
      3'b001:  f3_sel = SEL_SLL;
      3'b010:  f3_sel = SEL_SLT;
      3'b011:  f3_sel = SEL_SLTU;
      3'b100:  f3_sel = SEL_XOR;
      3'b101:  f3_sel = SEL_SRL;
      3'b110:  f3_sel = SEL_OR;
      default: f3_sel = SEL_AND;
    endcase
  endfunction

  // ---------------- decode ----------------
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       bad;
  entry_t     dec;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    dec     = '0;
    dec.rd  = instr[11:7];
    dec.sel = SEL_PASS;
    bad     = 1'b0;
    case (opc)
      OPC_R: begin
        dec.opa = rs1_data;
        dec.opb = rs2_data;
        if (f7 == F7_ZERO)                     dec.sel = f3_sel(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) dec.sel = SEL_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) dec.sel = SEL_SRA;
        else                                   bad     = 1'b1;
      end
      OPC_I: begin
        dec.opa = rs1_data;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediate: only the 5-bit shamt is an operand, upper bits select the variant.
          dec.opb = {{(XLEN-5){1'b0}}, instr[24:20]};
          if (f7 == F7_ZERO)                     dec.sel = f3_sel(f3);
          else if (f7 == F7_ALT && f3 == 3'b101) dec.sel = SEL_SRA;
          else                                   bad     = 1'b1;
        end else begin
          dec.opb = {{(XLEN-12){instr[31]}}, instr[31:20]};
          dec.sel = f3_sel(f3);
        end
      end
      OPC_LUI: begin
        dec.opa = {instr[31:12], 12'b0};
        dec.opb = '0;
        dec.sel = SEL_PASS;
      end
      default: bad = 1'b1;
    endcase
    // Unsupported encodings still travel through the buffer, but with zeroed operands.
    if (bad) begin
      dec.opa = '0;
      dec.opb = '0;
      dec.sel = SEL_PASS;
      dec.ill = 1'b1;
    end
  end

  // ---------------- 2-entry FIFO ----------------
  entry_t     mem [2];
  logic       wptr, rptr;
  logic [1:0] count;
  logic       push, pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Clearing storage makes the head outputs read as zero after reset.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= dec;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign opA       = mem[rptr].opa;
  assign opB       = mem[rptr].opb;
  assign aluOutSel = mem[rptr].sel;
  assign rd        = mem[rptr].rd;
  assign illegal   = mem[rptr].ill;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instr, rs1_data, rs2_data, opA, opB;
  logic [3:0]  aluOutSel;
  logic [4:0]  rd;

  int tests = 0;
  int fails = 0;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opA(opA), .opB(opB), .aluOutSel(aluOutSel), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference decode: classify the instruction, then look up the ALU operation.
  // Result packed as {opA, opB, sel, rd, illegal}.
  function automatic logic [73:0] ref_dec(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    logic [3:0] base [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       ok, shift;
    logic [31:0] ra, rb;
    logic [3:0]  s;
    base = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd2, 4'd8, 4'd3, 4'd4};
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ok = 1'b0; ra = 0; rb = 0; s = 4'hF;
    if (op == 7'h33) begin
      ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      ra = a; rb = b;
      s  = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd9) : base[f3];
    end else if (op == 7'h13) begin
      shift = (f3 == 1 || f3 == 5);
      ok = !shift || f7 == 0 || (f7 == 7'h20 && f3 == 5);
      ra = a;
      rb = shift ? 32'(w[24:20]) : 32'($signed(w[31:20]));
      s  = (shift && f7 == 7'h20) ? 4'd9 : base[f3];
    end else if (op == 7'h37) begin
      ok = 1'b1; ra = w & 32'hFFFFF000; rb = 0; s = 4'hF;
    end
    if (!ok) return {32'd0, 32'd0, 4'hF, w[11:7], 1'b1};
    return {ra, rb, s, w[11:7], 1'b0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, w;
    logic [6:0]  f7;
    int k;
    r = $urandom;
    k = $urandom_range(0, 5);
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case (k)
      0: w = {f7, r[24:7], 7'h33};
      1: w = {r[31:7], 7'h13};
      2: w = {f7, r[24:15], (r[0] ? 3'b101 : 3'b001), r[11:7], 7'h13};
      3: w = {r[31:7], 7'h37};
      4: w = r;
      default: w = {r[31:7], 7'h7F};
    endcase
    return w;
  endfunction

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; instr = 0; rs1_data = 0; rs2_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, opA, opB, aluOutSel, rd, illegal} !== {1'b1, 1'b0, 74'd0}) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b opA=%h opB=%h sel=%h rd=%0d ill=%b, want 1 0 and all zero",
               in_ready, out_valid, opA, opB, aluOutSel, rd, illegal);
    end
  endtask

  // Directed decode vectors: instr, rs1, rs2 -> opA, opB, sel, rd, illegal.
  task automatic test_decode();
    logic [31:0] vi [6] = '{32'h40208033, 32'hFFF00093, 32'h40315093, 32'h123450B7, 32'h0000007F, 32'h40004033};
    logic [31:0] v1 [6] = '{32'd10, 32'd5, 32'h80000000, 32'd7, 32'd7, 32'd7};
    logic [31:0] v2 [6] = '{32'd3, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
    logic [73:0] ve [6] = '{{32'd10, 32'd3, 4'h1, 5'd0, 1'b0},
                            {32'd5, 32'hFFFFFFFF, 4'h0, 5'd1, 1'b0},
                            {32'h80000000, 32'd3, 4'h9, 5'd1, 1'b0},
                            {32'h12345000, 32'd0, 4'hF, 5'd1, 1'b0},
                            {32'd0, 32'd0, 4'hF, 5'd0, 1'b1},
                            {32'd0, 32'd0, 4'hF, 5'd0, 1'b1}};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1; out_ready = 1; instr = vi[i]; rs1_data = v1[i]; rs2_data = v2[i];
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      tests++;
      if ({out_valid, opA, opB, aluOutSel, rd, illegal} !== {1'b1, ve[i]}) begin
        fails++;
        $display("FAIL decode[%0d] instr=%h: got v=%b %h %h sel=%h rd=%0d ill=%b, want v=1 %h", i, vi[i],
                 out_valid, opA, opB, aluOutSel, rd, illegal, ve[i]);
      end
    end
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    // addi x<k>, x0, 0 with rs1 = k: entries distinguishable by rd and opA.
    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; instr = {25'd1, 7'h13}; rs1_data = 1;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL b2b_first: rdy/vld=%b want 10", {in_ready, out_valid}); end
    @(posedge clk); #1;
    instr = {25'd2, 7'h13}; rs1_data = 2;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, rd} !== {2'b11, 5'd1}) begin fails++; $display("FAIL b2b_second: rdy/vld/rd=%b/%0d want 11/1", {in_ready, out_valid}, rd); end
    @(posedge clk); #1;
    instr = {25'd3, 7'h13}; rs1_data = 3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({in_ready, out_valid, rd, opA} !== {2'b01, 5'd1, 32'd1}) begin
        fails++; $display("FAIL b2b_stall%0d: rdy=%b vld=%b rd=%0d opA=%0d want 0 1 1 1", c, in_ready, out_valid, rd, opA);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    tests++;
    if ({in_ready, rd} !== {1'b0, 5'd1}) begin fails++; $display("FAIL b2b_pop1: rdy=%b rd=%0d want 0 1", in_ready, rd); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, rd} !== {2'b11, 5'd2}) begin fails++; $display("FAIL b2b_pop2: rdy=%b vld=%b rd=%0d want 1 1 2", in_ready, out_valid, rd); end
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    tests++;
    if ({out_valid, rd, opA} !== {1'b1, 5'd3, 32'd3}) begin fails++; $display("FAIL b2b_pop3: vld=%b rd=%0d opA=%0d want 1 3 3", out_valid, rd, opA); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_flush();
    in_valid = 1; out_ready = 0; instr = {25'd4, 7'h13}; rs1_data = 4;
    repeat (2) @(posedge clk);
    #1 flush = 1; instr = {25'd5, 7'h13};
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL flush: vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    // The buffer must still work after a flush.
    @(posedge clk); #1;
    in_valid = 1; instr = {25'd6, 7'h13}; rs1_data = 6;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    tests++;
    if ({out_valid, rd} !== {1'b1, 5'd6}) begin fails++; $display("FAIL flush_after: vld=%b rd=%0d want 1 6", out_valid, rd); end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_rst_mid();
    in_valid = 1; out_ready = 0; instr = 32'h40208033; rs1_data = 10; rs2_data = 3;
    @(posedge clk); #1;
    in_valid = 0; rst = 1; flush = 1;
    @(posedge clk); #1;
    rst = 0; flush = 0; out_ready = 1;
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, opA, opB, aluOutSel, rd, illegal} !== {1'b1, 1'b0, 74'd0}) begin
      fails++;
      $display("FAIL rst_mid: rdy=%b vld=%b opA=%h opB=%h sel=%h rd=%0d ill=%b, want 1 0 and zeros",
               in_ready, out_valid, opA, opB, aluOutSel, rd, illegal);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_noemit: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_random();
    logic [73:0] q[$];
    logic [73:0] head;
    int n_before;
    int nfail_local;
    nfail_local = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      instr     = rand_instr();
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      @(negedge clk);
      tests++;
      head = (q.size() != 0) ? q[0] : 74'd0;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0) ||
          (q.size() != 0 && {opA, opB, aluOutSel, rd, illegal} !== head)) begin
        fails++;
        if (nfail_local++ < 10)
          $display("FAIL random cycle %0d: rdy=%b vld=%b out=%h, want rdy=%b vld=%b out=%h",
                   c, in_ready, out_valid, {opA, opB, aluOutSel, rd, illegal}, q.size() < 2, q.size() != 0, head);
      end
      n_before = q.size();
      if (flush) q.delete();
      else begin
        if (n_before != 0 && out_ready) void'(q.pop_front());
        if (in_valid && n_before < 2) q.push_back(ref_dec(instr, rs1_data, rs2_data));
      end
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; instr = 0; rs1_data = 0; rs2_data = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
